// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that lets two requesters share one APB master port.
// Optional macro APB_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT_CYCLES cycles with err=1.
module apb_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state_q, state_d;
    logic rr_q, rr_d;
    logic gnt_q, gnt_d;
    logic gnt_c;
    logic any_valid;
    logic finish;
    logic tmo_hit;

    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [1:0][31:0] rdata_q, rdata_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // rr_q names the requester that wins a tie; a lone requester wins regardless
    assign any_valid = req0_valid | req1_valid;
    assign gnt_c     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign finish    = (state_q == ACCESS) && (PREADY || tmo_hit);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    // Count completed wait cycles of the current ACCESS phase, cleared outside it
    always_comb begin
        tmo_d = (state_q == ACCESS && !PREADY && !tmo_hit) ? tmo_q + CW'(1) : '0;
    end

    // Timeout counter register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next state: one SETUP cycle, ACCESS until completion, at least one IDLE cycle in between
    always_comb begin
        state_d = (state_q == IDLE)   ? (any_valid ? SETUP : IDLE) :
                  (state_q == SETUP)  ? ACCESS :
                  (state_q == ACCESS && !finish) ? ACCESS : IDLE;
        rr_d    = (state_q == IDLE && any_valid) ? ~gnt_c : rr_q;
        gnt_d   = (state_q == IDLE && any_valid) ? gnt_c : gnt_q;
    end

    // Output next values: command latched at grant, results loaded into the granted slot at completion
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        ready_d   = '0;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (state_q == IDLE && any_valid) begin
            psel_d          = 1'b1;
            penable_d       = 1'b0;
            pwrite_d        = gnt_c ? req1_write : req0_write;
            paddr_d         = gnt_c ? req1_addr  : req0_addr;
            pwdata_d        = gnt_c ? req1_wdata : req0_wdata;
            ready_d[gnt_c]  = 1'b1;
        end else if (state_q == SETUP) begin
            penable_d = 1'b1;
        end else if (finish) begin
            psel_d         = 1'b0;
            penable_d      = 1'b0;
            done_d[gnt_q]  = 1'b1;
            rdata_d[gnt_q] = (tmo_hit || pwrite_q) ? '0 : PRDATA;
            err_d[gnt_q]   = tmo_hit | PSLVERR;
        end
    end

    // Output registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ready_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized requesters and APB slave checked against a transfer-level model.
module tb_apb_req_arbiter;
`ifdef APB_TIMEOUT_EN
    localparam int TMO = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO = 16;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        PCLK, PRESET;
    logic [1:0]  v, wr;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    apb_req_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(v[0]), .req0_write(wr[0]), .req0_addr(ad[0]), .req0_wdata(wd[0]),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(v[1]), .req1_write(wr[1]), .req1_addr(ad[1]), .req1_wdata(wd[1]),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard entries: which requester, and the cycle the pulse must appear in
    typedef struct { int id; int cyc; } ev_t;
    ev_t q_rdy[$];
    ev_t q_done[$];
    ev_t e;

    // Transfer-level reference: busy phase 0=free,1=setup,2=access
    int          cyc = 0;
    int          m_ph, m_acc, m_last, m_id;
    logic        m_psel, m_pen, m_wr;
    logic [31:0] m_ad, m_wd;
    logic [31:0] m_rd [2];
    logic [1:0]  m_err;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_ph = 0; m_acc = 0; m_last = 1; m_id = 0;
            m_psel = 0; m_pen = 0; m_wr = 0; m_ad = 0; m_wd = 0;
            m_rd[0] = 0; m_rd[1] = 0; m_err = 0;
            q_rdy.delete();
            q_done.delete();
        end else begin
            cyc++;
            if (m_ph == 0) begin
                if (v != 2'b00) begin
                    m_id   = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
                    m_last = m_id;
                    m_wr = wr[m_id]; m_ad = ad[m_id]; m_wd = wd[m_id];
                    m_psel = 1; m_pen = 0; m_ph = 1;
                    q_rdy.push_back('{m_id, cyc});
                end
            end else if (m_ph == 1) begin
                m_pen = 1; m_ph = 2; m_acc = 0;
            end else begin
                m_acc++;
                if (PREADY || (TMO_EN && m_acc == TMO)) begin
                    m_rd[m_id]  = (!PREADY || m_wr) ? 32'd0 : PRDATA;
                    m_err[m_id] = !PREADY || PSLVERR;
                    m_psel = 0; m_pen = 0; m_ph = 0;
                    q_done.push_back('{m_id, cyc});
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model mid-cycle
    always @(negedge PCLK) begin
        logic [1:0] er, ed;
        er = 2'b00;
        ed = 2'b00;
        if (q_rdy.size() != 0 && q_rdy[0].cyc == cyc) begin
            e = q_rdy.pop_front();
            er[e.id] = 1'b1;
        end
        if (q_done.size() != 0 && q_done[0].cyc == cyc) begin
            e = q_done.pop_front();
            ed[e.id] = 1'b1;
        end
        chk("ready", {req1_ready, req0_ready}, er);
        chk("done", {req1_done, req0_done}, ed);
        chk("psel_penable", {PSEL, PENABLE}, {m_psel, m_pen});
        if (m_psel) chk("apb_cmd", {PWRITE, PADDR, PWDATA}, {m_wr, m_ad, m_wd});
        if (PRESET) chk("reset_cmd", {PWRITE, PADDR, PWDATA}, 65'd0);
        chk("rdata0", req0_rdata, m_rd[0]);
        chk("rdata1", req1_rdata, m_rd[1]);
        chk("err", {req1_err, req0_err}, m_err);
    end

    // One requester/slave cycle: accepted commands drop, new ones appear at random
    task automatic step(input int newp, input int drop, input int rdyp);
        logic [1:0] acc;
        @(negedge PCLK);
        acc = {req1_ready, req0_ready};
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) v[n] = 1'b0;
            else if (v[n] && $urandom_range(99) < drop) v[n] = 1'b0;
            else if (!v[n] && $urandom_range(99) < newp) begin
                v[n]  = 1'b1;
                wr[n] = 1'($urandom_range(1));
                ad[n] = $urandom;
                wd[n] = $urandom;
            end
        end
        if (rdyp >= 0) begin
            PREADY  = ($urandom_range(99) < rdyp);
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(3) == 0);
        end
    endtask

    task automatic run(input int n, input int newp, input int drop, input int rdyp);
        for (int i = 0; i < n; i++) step(newp, drop, rdyp);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        #1 PRESET = 1'b1;
        v = 2'b00;
        repeat (2) @(negedge PCLK);
        #1 PRESET = 1'b0;
    endtask

    initial begin
        int k;
        PRESET = 1'b1; v = 2'b00; wr = 2'b00;
        ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;
        PREADY = 1'b0; PRDATA = 0; PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        #1 PRESET = 1'b0;
        // Write from requester 0, zero wait states
        @(negedge PCLK);
        v[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h10; wd[0] = 32'hDEADBEEF;
        PREADY = 1'b1; PSLVERR = 1'b0;
        run(6, 0, 0, -1);
        // Read from requester 1 with three wait states
        v[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'h20;
        PREADY = 1'b0; PRDATA = 32'h12345678;
        run(5, 0, 0, -1);
        PREADY = 1'b1;
        run(4, 0, 0, -1);
        // Read from requester 0 that ends in a slave error
        v[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h30;
        PRDATA = 32'hCAFEF00D; PSLVERR = 1'b1;
        run(5, 0, 0, -1);
        PSLVERR = 1'b0;
        // Both requesters continuously valid straight after reset
        do_reset();
        PREADY = 1'b1;
        run(30, 100, 0, -1);
        run(5, 0, 0, -1);
        // Reset raised while a transfer sits in ACCESS
        @(negedge PCLK);
        v[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'h44; PREADY = 1'b0;
        k = 0;
        while (!(PSEL && PENABLE) && k < 20) begin
            step(0, 0, -1);
            k++;
        end
        chk("reach_access", 32'(k < 20), 32'd1);
        do_reset();
        PREADY = 1'b1;
        run(20, 100, 0, -1);
        // Random traffic with random wait states, drops and errors
        run(1500, 30, 5, 60);
        // Slave stalls with PREADY held low
        PREADY = 1'b0;
        run(110, 100, 0, -1);
`ifndef APB_TIMEOUT_EN
        chk("stall_wait", {PSEL, PENABLE, req1_done, req0_done}, 4'b1100);
`endif
        PREADY = 1'b1;
        run(30, 0, 0, -1);
        chk("scoreboard_empty", 64'(q_rdy.size() + q_done.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles waited for PREADY before abort (used only with APB_TIMEOUT_EN).
REQ-002 The block SHALL have port PCLK, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port PRESET, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have, for each N in {0,1}, port reqN_valid, input, 1, meaning a command is pending.
REQ-005 The block SHALL have, for each N, ports reqN_write (input, 1), reqN_addr (input, 32) and reqN_wdata (input, 32), meaning command direction, address and write data.
REQ-006 The block SHALL have, for each N, port reqN_ready, output, 1, a one-cycle pulse meaning the command is accepted.
REQ-007 The block SHALL have, for each N, ports reqN_done (output, 1), reqN_rdata (output, 32) and reqN_err (output, 1), meaning transfer complete, read data and error status.
REQ-008 The block SHALL have APB outputs PSEL (1), PENABLE (1), PWRITE (1), PADDR (32) and PWDATA (32).
REQ-009 The block SHALL have APB inputs PRDATA (32), PREADY (1) and PSLVERR (1).

Function
REQ-010 The FSM SHALL have states IDLE, SETUP and ACCESS, with every output registered.
REQ-011 In IDLE with any reqN_valid high, the block SHALL grant one requester, latch its write/addr/wdata into PWRITE/PADDR/PWDATA and move to SETUP with PSEL=1, PENABLE=0.
REQ-012 The block SHALL assert the granted reqN_ready for exactly the cycle spent in SETUP; the requester holds valid and command stable until it sees ready.
REQ-013 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; after reset, requester 0 wins a tie.
REQ-014 A single valid requester SHALL be granted regardless of pointer; the pointer updates only on a grant.
REQ-015 SETUP SHALL last exactly one cycle, then ACCESS with PENABLE=1; PSEL, PADDR, PWRITE and PWDATA SHALL stay stable through ACCESS.
REQ-016 In ACCESS with PREADY low, the block SHALL hold all APB outputs (wait states unlimited unless APB_TIMEOUT_EN is defined).
REQ-017 In ACCESS with PREADY high, the block SHALL, at that edge, drive PSEL=0 and PENABLE=0, return to IDLE, and pulse the granted reqN_done for one cycle.
REQ-018 On completion, reqN_rdata SHALL load PRDATA for reads and 0 for writes, reqN_err SHALL load PSLVERR, and both SHALL hold until that requester's next done.
REQ-019 The other requester's done/rdata/err SHALL be unaffected by the transfer.
REQ-020 After completion, IDLE SHALL last at least one cycle, so back-to-back transfers take 3 cycles each with zero wait states; IDLE never overlaps SETUP.
REQ-021 reqN_valid SHALL be ignored outside IDLE, and a requester deasserting valid before grant SHALL be dropped without side effects.

Reset
REQ-022 While PRESET is high, the block SHALL force state=IDLE, PSEL, PENABLE, PWRITE, PADDR and PWDATA to 0, all ready/done/err to 0, all rdata to 0, round-robin pointer to "requester 0 next" and the timeout counter to 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse, and operation SHALL resume from IDLE at the first edge after release.

Configuration
REQ-024 With macro APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if PREADY is still low in the TIMEOUT_CYCLES-th ACCESS cycle, the block SHALL end the transfer as in REQ-017 with reqN_err=1 and reqN_rdata=0.
REQ-025 With APB_TIMEOUT_EN undefined, the block SHALL have no counter and SHALL wait for PREADY indefinitely.

Verification
REQ-026 Req0 write addr 0x10 data 0xDEADBEEF, PREADY=1 -> PSEL high 2 cycles, PENABLE high 1 cycle, req0_ready then req0_done pulses, req0_err=0.
REQ-027 Req1 read addr 0x20, PRDATA=0x12345678, PREADY low 3 ACCESS cycles -> APB signals held, then req1_done with req1_rdata=0x12345678.
REQ-028 Both valid continuously after reset -> grant order 0,1,0,1, each transfer 3 cycles, one IDLE cycle between transfers.
REQ-029 Read with PSLVERR=1 at PREADY -> req0_err=1, req0_rdata=PRDATA, req1 outputs unchanged.
REQ-030 PRESET raised in ACCESS -> all outputs 0 immediately, no done; next transfer after release starts with requester 0.
REQ-031 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck low -> done after 4th ACCESS cycle, err=1, rdata=0; without the macro, still waiting after 100 cycles.
